// File: rtl/pz_acc_sequencer_if.sv
// Bundle between the control logic, the pole/zero register file read port and
// the accumulation sequencer. The sequencer connects through the slave modport.
interface pz_acc_sequencer_if #(
  parameter int unsigned ADDR_W = 4
);
  logic                start;
  logic                busy;
  logic                done;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic signed [15:0]  rd_data;
  logic signed [15:0]  acc_pz;
  logic                ovf;

  // Environment side: issues start requests and returns register-file data.
  modport master (
    output start,
    output rd_data,
    input  busy,
    input  done,
    input  rd_en,
    input  rd_addr,
    input  acc_pz,
    input  ovf
  );

  // Sequencer side.
  modport slave (
    input  start,
    input  rd_data,
    output busy,
    output done,
    output rd_en,
    output rd_addr,
    output acc_pz,
    output ovf
  );
endinterface

// File: rtl/pz_acc_sequencer.sv
// Pole/zero accumulation sequencer. On start it reads REG_FILE_SIZE signed
// 16-bit entries (one address per cycle), sums them and publishes the result
// with a one-cycle done pulse. Optional macro PZ_SAT_EN turns every add into a
// saturating add; otherwise adds wrap. ovf is sticky over one pass.
module pz_acc_sequencer #(
  parameter int unsigned REG_FILE_SIZE = 2,
  parameter int unsigned ADDR_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  pz_acc_sequencer_if.slave bus_io
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(REG_FILE_SIZE - 1);

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_en_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               rd_vld_q;
  logic signed [15:0] sum_q;
  logic signed [15:0] sum_d;
  logic               ovf_acc_q;
  logic               ovf_acc_d;
  logic signed [15:0] acc_pz_q;
  logic               ovf_q;

  logic signed [15:0] add_wrap;
  logic signed [15:0] add_res;
  logic               add_ovf;

  // One signed add of the incoming entry; overflow when both operands share a
  // sign that the wrapped result does not.
  always_comb begin
    add_wrap = sum_q + bus_io.rd_data;
    add_ovf  = (sum_q[15] == bus_io.rd_data[15]) && (add_wrap[15] != sum_q[15]);
`ifdef PZ_SAT_EN
    if (add_ovf) begin
      add_res = sum_q[15] ? 16'sh8000 : 16'sh7fff;
    end else begin
      add_res = add_wrap;
    end
`else
    add_res = add_wrap;
`endif
  end

  // Accumulate whenever read data returned by the register file is valid.
  always_comb begin
    sum_d     = sum_q;
    ovf_acc_d = ovf_acc_q;
    if (rd_vld_q) begin
      sum_d     = add_res;
      ovf_acc_d = ovf_acc_q | add_ovf;
    end
  end

  // Sequencing FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      sum_q     <= '0;
      ovf_acc_q <= 1'b0;
      acc_pz_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rd_vld_q  <= rd_en_q;
      sum_q     <= sum_d;
      ovf_acc_q <= ovf_acc_d;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_q   <= StRead;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            sum_q     <= '0;
            ovf_acc_q <= 1'b0;
          end
        end
        StRead: begin
          if (rd_addr_q == LastAddr) begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        StDrain: begin
          // Final entry is added this cycle; publish the completed sum so it is
          // visible alongside the done pulse.
          state_q  <= StDone;
          done_q   <= 1'b1;
          acc_pz_q <= sum_d;
          ovf_q    <= ovf_acc_d;
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.busy    = busy_q;
  assign bus_io.done    = done_q;
  assign bus_io.rd_en   = rd_en_q;
  assign bus_io.rd_addr = rd_addr_q;
  assign bus_io.acc_pz  = acc_pz_q;
  assign bus_io.ovf     = ovf_q;

endmodule

// File: tb/tb_pz_acc_sequencer.sv
// Bench for pz_acc_sequencer: three instances (N = 2, 4, 1) sharing clock and
// reset, each with its own register-file model. Expected sums come from a
// plain-integer reference of the wrap/saturate rules.
module tb_pz_acc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]         start_v = '0;
  logic [2:0]         busy_v;
  logic [2:0]         done_v;
  logic [2:0]         rd_en_v;
  logic [3:0]         addr_v [3];
  logic signed [15:0] acc_v  [3];
  logic [2:0]         ovf_v;

  logic signed [15:0] mem [3][16];
  logic signed [15:0] exp_acc [3];
  logic               exp_ovf [3];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NG = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    pz_acc_sequencer_if #(.ADDR_W(4)) u_if ();
    pz_acc_sequencer #(.REG_FILE_SIZE(NG), .ADDR_W(4)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .bus_io(u_if)
    );
    assign u_if.start = start_v[g];
    // Register file: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
      if (u_if.rd_en) u_if.rd_data <= mem[g][u_if.rd_addr];
      else            u_if.rd_data <= 16'($urandom);
    end
    assign busy_v[g]  = u_if.busy;
    assign done_v[g]  = u_if.done;
    assign rd_en_v[g] = u_if.rd_en;
    assign addr_v[g]  = u_if.rd_addr;
    assign acc_v[g]   = u_if.acc_pz;
    assign ovf_v[g]   = u_if.ovf;
  end

  function automatic int nsel(input int sel);
    return (sel == 0) ? 2 : ((sel == 1) ? 4 : 1);
  endfunction

  // Reference: integer running sum, wrapped or clamped after every add.
  function automatic void model(input int sel, output logic signed [15:0] r, output logic o);
    int s = 0;
    o = 1'b0;
    for (int i = 0; i < nsel(sel); i++) begin
      s = s + int'(mem[sel][i]);
`ifdef PZ_SAT_EN
      if (s > 32767) begin s = 32767; o = 1'b1; end
      else if (s < -32768) begin s = -32768; o = 1'b1; end
`else
      if (s > 32767) begin s = s - 65536; o = 1'b1; end
      else if (s < -32768) begin s = s + 65536; o = 1'b1; end
`endif
    end
    r = 16'(s);
  endfunction

  task automatic load_random(input int sel);
    int mode = $urandom_range(0, 2);
    for (int i = 0; i < 16; i++) begin
      if (mode == 0) mem[sel][i] = 16'($urandom);
      else if (mode == 1) mem[sel][i] = 16'($signed($urandom_range(0, 2000)) - 1000);
      else mem[sel][i] = ($urandom_range(0, 1) == 1) ? 16'sd30000 : -16'sd30000;
    end
  endtask

  // Full timed pass: start at edge 0, checks every cycle 1..N+3.
  task automatic run_pass(input int sel);
    int n = nsel(sel);
    logic signed [15:0] er;
    logic eo;
    logic signed [15:0] ea;
    logic ee;
    model(sel, er, eo);
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clk);
      if (c == 1) start_v[sel] = 1'b0;
      ea = (c >= n + 2) ? er : exp_acc[sel];
      ee = (c >= n + 2) ? eo : exp_ovf[sel];
      total += 6;
      if (busy_v[sel] !== (c <= n + 2)) begin
        bad++; $display("FAIL pass_busy i%0d c%0d got=%b exp=%b", sel, c, busy_v[sel], c <= n + 2);
      end
      if (done_v[sel] !== (c == n + 2)) begin
        bad++; $display("FAIL pass_done i%0d c%0d got=%b exp=%b", sel, c, done_v[sel], c == n + 2);
      end
      if (rd_en_v[sel] !== (c <= n)) begin
        bad++; $display("FAIL pass_rd_en i%0d c%0d got=%b exp=%b", sel, c, rd_en_v[sel], c <= n);
      end
      if (addr_v[sel] !== 4'((c <= n) ? c - 1 : n - 1)) begin
        bad++; $display("FAIL pass_addr i%0d c%0d got=%0d exp=%0d", sel, c, addr_v[sel],
                        (c <= n) ? c - 1 : n - 1);
      end
      if (acc_v[sel] !== ea) begin
        bad++; $display("FAIL pass_acc i%0d c%0d got=%0d exp=%0d", sel, c, acc_v[sel], ea);
      end
      if (ovf_v[sel] !== ee) begin
        bad++; $display("FAIL pass_ovf i%0d c%0d got=%b exp=%b", sel, c, ovf_v[sel], ee);
      end
    end
    exp_acc[sel] = er;
    exp_ovf[sel] = eo;
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 3; s++) begin
      total++;
      if (busy_v[s] !== 1'b0 || done_v[s] !== 1'b0 || rd_en_v[s] !== 1'b0 ||
          addr_v[s] !== 4'd0 || acc_v[s] !== 16'sd0 || ovf_v[s] !== 1'b0) begin
        bad++;
        $display("FAIL %s i%0d got busy=%b done=%b rd_en=%b addr=%0d acc=%0d ovf=%b exp all 0",
                 tag, s, busy_v[s], done_v[s], rd_en_v[s], addr_v[s], acc_v[s], ovf_v[s]);
      end
      exp_acc[s] = '0;
      exp_ovf[s] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    mem[0][0] = 16'sd100;
    mem[0][1] = -16'sd30;
    run_pass(0);
    total++;
    if (acc_v[0] !== 16'sd70 || ovf_v[0] !== 1'b0) begin
      bad++; $display("FAIL basic_70 got=%0d/%b exp=70/0", acc_v[0], ovf_v[0]);
    end
  endtask

  task automatic test_overflow();
    mem[0][0] = 16'sd30000;
    mem[0][1] = 16'sd10000;
    run_pass(0);
    mem[1][0] = -16'sd20000;
    mem[1][1] = -16'sd20000;
    mem[1][2] = 16'sd30000;
    mem[1][3] = 16'sd0;
    run_pass(1);
  endtask

  task automatic test_single_entry();
    for (int k = 0; k < 3; k++) begin
      load_random(2);
      run_pass(2);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < 3; s++) begin
        load_random(s);
        run_pass(s);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dcnt = 0;
    logic signed [15:0] er;
    logic eo;
    load_random(0);
    model(0, er, eo);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      // Both reads are done by now; a second pass would see different data.
      if (c == 3) for (int i = 0; i < 2; i++) mem[0][i] = mem[0][i] + 16'sd7;
      if (c == 5) start_v[0] = 1'b0;
      if (done_v[0] === 1'b1) dcnt++;
      if (c == 4) begin
        total++;
        if (done_v[0] !== 1'b1) begin
          bad++; $display("FAIL ignore_done_c4 got=%b exp=1", done_v[0]);
        end
      end
    end
    total += 2;
    if (dcnt != 1) begin
      bad++; $display("FAIL ignore_done_count got=%0d exp=1", dcnt);
    end
    if (acc_v[0] !== er || ovf_v[0] !== eo) begin
      bad++; $display("FAIL ignore_acc got=%0d/%b exp=%0d/%b", acc_v[0], ovf_v[0], er, eo);
    end
    exp_acc[0] = er;
    exp_ovf[0] = eo;
  endtask

  task automatic test_reset_mid();
    int dcnt = 0;
    mem[1][0] = 16'sd100;
    mem[1][1] = -16'sd30;
    mem[1][2] = 16'sd0;
    mem[1][3] = 16'sd0;
    run_pass(1);
    total++;
    if (acc_v[1] !== 16'sd70) begin
      bad++; $display("FAIL rstmid_prior got=%0d exp=70", acc_v[1]);
    end
    load_random(1);
    @(negedge clk);
    start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    total++;
    if (busy_v[1] !== 1'b1) begin
      bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy_v[1]);
    end
    #1 rst = 1'b1;
    #1 check_all_zero("rstmid_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_v[1] === 1'b1 || busy_v[1] === 1'b1) dcnt++;
    end
    total++;
    if (dcnt != 0) begin
      bad++; $display("FAIL rstmid_no_done got=%0d active cycles exp=0", dcnt);
    end
    run_pass(1);
  endtask

  task automatic test_back_to_back();
    mem[0][0] = 16'sd1;
    mem[0][1] = 16'sd2;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      total++;
      if (done_v[0] !== ((c % 5) == 4)) begin
        bad++; $display("FAIL b2b_done c%0d got=%b exp=%b", c, done_v[0], (c % 5) == 4);
      end
      if ((c % 5) == 4) begin
        total++;
        if (acc_v[0] !== 16'sd3 || ovf_v[0] !== 1'b0) begin
          bad++; $display("FAIL b2b_acc c%0d got=%0d/%b exp=3/0", c, acc_v[0], ovf_v[0]);
        end
      end
    end
    start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (busy_v[0] !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got busy=%b exp=0", busy_v[0]);
    end
    exp_acc[0] = 16'sd3;
    exp_ovf[0] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 16; i++) mem[s][i] = '0;
      exp_acc[s] = '0;
      exp_ovf[s] = 1'b0;
    end
    test_reset();
    test_basic();
    test_overflow();
    test_single_entry();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pz_acc_sequencer.md
# pz_acc_sequencer

Controller that sequences accumulation of the pole/zero register file. On a start request it walks all REG_FILE_SIZE 16-bit signed entries through a read port, one address per cycle, sums them in a 16-bit accumulator, then publishes the result with a one-cycle done pulse. It sits between the control logic and the pole/zero register file, and replaces free-running accumulation with a deterministic, handshaked pass.

## Interface

- REG_FILE_SIZE, 2, number of 16-bit entries summed per pass (≥1)
- ADDR_W, 4, read address width; 2^ADDR_W ≥ REG_FILE_SIZE
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a pass; sampled only in IDLE
- busy  out  1  high from first READ cycle through DONE
- done  out  1  one-cycle pulse; acc_pz/ovf valid from this cycle
- rd_en  out  1  read strobe to register file
- rd_addr  out  ADDR_W  entry index, 0..REG_FILE_SIZE-1
- rd_data  in  16  signed entry; valid exactly 1 cycle after rd_en
- acc_pz  out  16  signed result of last completed pass
- ovf  out  1  last pass overflowed (wrap) or clamped (saturation)

## Operation

- States: IDLE, READ, DRAIN, DONE; all outputs registered.
- IDLE: start=1 → READ; internal sum and overflow flag cleared to 0; read counter = 0.
- READ: rd_en=1, rd_addr=counter, counter++; after address REG_FILE_SIZE-1 is issued → DRAIN.
- Accumulate: rd_vld = rd_en delayed 1 cycle; when rd_vld=1, sum ← sum + rd_data (signed, 16-bit).
- DRAIN: rd_en=0; last rd_data accumulated this cycle → DONE.
- DONE: acc_pz ← sum, ovf ← overflow flag, done=1 → IDLE.
- Signed overflow on any add: result of that add wraps (two's complement); overflow flag set (sticky for the pass).
- acc_pz/ovf change only in DONE; they hold the previous result throughout a pass.
- start outside IDLE ignored (no queuing). start held high in IDLE after DONE starts a new pass back-to-back.
- rd_addr holds last issued value when rd_en=0.

## Timing

- Reset (async assert): state IDLE, busy=0, done=0, rd_en=0, rd_addr=0, acc_pz=0, ovf=0, sum=0. Reset mid-pass aborts; no done pulse, acc_pz returns to 0.
- start sampled high at edge 0 → cycles 1..N: READ, rd_addr 0..N-1 (N=REG_FILE_SIZE).
- Cycle N+1: DRAIN. Cycle N+2: DONE, done=1, acc_pz valid. Cycle N+3: IDLE.
- Latency start→done: N+2 cycles; busy high N+2 cycles (cycles 1..N+2).
- N=1: READ one cycle, same sequence, done at cycle 3.
- Minimum pass spacing: N+3 cycles.

## Configuration

- PZ_SAT_EN defined: each add saturates to +32767 / −32768 instead of wrapping; ovf set if any add clamped. Saturation is per-step, so the result depends on entry order.
- PZ_SAT_EN undefined: wrapping arithmetic as in Operation; ovf reports signed overflow.

## Test plan

- N=2, entries {100, −30}, start at cycle 0 → rd_addr 0,1 at cycles 1,2; done at cycle 4; acc_pz=70, ovf=0; busy cycles 1–4.
- N=2, entries {30000, 10000} → without PZ_SAT_EN acc_pz=−25536, ovf=1; with it acc_pz=32767, ovf=1.
- N=4, entries {−20000, −20000, 30000, 0} → without macro acc_pz=−10000, ovf=1; with PZ_SAT_EN acc_pz=−2768, ovf=1.
- Pulse start again during cycles 1–4 of a pass → ignored; exactly one done pulse; acc_pz from the first pass only.
- Assert rst at cycle 2 of an N=4 pass after a prior result of 70 → all outputs 0 immediately, no done; next start runs a clean pass.
- Hold start high continuously, N=2, entries {1, 2} → done at cycles 4, 9, 14…; acc_pz=3, ovf=0 each time.
